// File: rtl/bram_block_sched.sv
// Word-to-block packer and single-port arbiter for the 512-bit block memory.
// Incoming 32-bit words are written MSB slice first, 16 per block; the memory
// is used as a circular block FIFO and blocks are handed to the hash core.
module bram_block_sched #(
   parameter int unsigned DEPTH  = 500,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned CNT_W  = 9
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [511:0]      out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [8:0]        bram_addr_width,
   output logic              bram_cs_n,
   output logic              bram_wr_n,
   output logic              bram_rd_n,
   output logic [31:0]       bram_wdata,
   input  logic [511:0]      bram_rdata,
   output logic [CNT_W-1:0]  blocks_stored,
   output logic [3:0]        word_idx
);

   localparam int unsigned IDX_W = 4;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(15);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  blocks_q, blocks_d;
   logic [IDX_W-1:0]  word_idx_q, word_idx_d;
   logic              out_valid_q, out_valid_d;
   logic              rd_go;
   logic              wr_go;

   // Arbitration, memory strobes and next-state; a pending read always wins.
   always_comb begin
      rd_go    = (blocks_q != '0) && !out_valid_q;
      in_ready = !reset && !rd_go && (blocks_q < FULL_CNT);
      wr_go    = in_valid && in_ready;

      bram_cs_n       = 1'b1;
      bram_wr_n       = 1'b1;
      bram_rd_n       = 1'b1;
      bram_addr       = wr_ptr_q;
      bram_addr_width = 9'd511 - {word_idx_q, 5'b00000};
      bram_wdata      = in_data;

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      blocks_d    = blocks_q;
      word_idx_d  = word_idx_q;
      out_valid_d = out_valid_q;

      if (rd_go) begin
         bram_cs_n   = 1'b0;
         bram_rd_n   = 1'b0;
         bram_addr   = rd_ptr_q;
         rd_ptr_d    = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_W'(1);
         blocks_d    = blocks_q - CNT_W'(1);
         out_valid_d = 1'b1;
      end else if (wr_go) begin
         bram_cs_n  = 1'b0;
         bram_wr_n  = 1'b0;
         word_idx_d = word_idx_q + IDX_W'(1);
         if (word_idx_q == LAST_WORD) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_W'(1);
            blocks_d = blocks_q + CNT_W'(1);
         end
      end

      // Read data stays parked in the memory output until the core takes it.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset; reset drops partial and stored blocks.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         blocks_q    <= '0;
         word_idx_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         blocks_q    <= blocks_d;
         word_idx_q  <= word_idx_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data      = bram_rdata;
   assign out_valid     = out_valid_q;
   assign blocks_stored = blocks_q;
   assign word_idx      = word_idx_q;

endmodule
